cache_trace_queue: RTL and testbench

Upstream request queue for the cache simulator: buffers trace accesses (read/write flag plus address) from the trace source and presents them one at a time on registered `rw`/`address` outputs under a valid/ready handshake. It decouples bursty trace delivery from the cache's per-clock consumption. It optionally counts issued reads and writes for cross-checking the cache's own access counters.

---
 rtl/cache_trace_queue_if.sv | 24 ++
 rtl/cache_trace_queue.sv | 151 +++++++++++++++
 tb/tb_cache_trace_queue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_trace_queue_if.sv
// Trace-access handshake bundle for cache_trace_queue: producer-side push
// channel and consumer-side request channel.
interface cache_trace_queue_if #(
   parameter int unsigned ADDRESS_SIZE = 16
);
   logic                    in_valid;
   logic                    in_rw;
   logic [ADDRESS_SIZE-1:0] in_address;
   logic                    in_ready;
   logic                    req_valid;
   logic                    rw;
   logic [ADDRESS_SIZE-1:0] address;
   logic                    cache_ready;

   modport master (
      output in_valid, in_rw, in_address, cache_ready,
      input  in_ready, req_valid, rw, address
   );

   modport slave (
      input  in_valid, in_rw, in_address, cache_ready,
      output in_ready, req_valid, rw, address
   );
endinterface

// File: rtl/cache_trace_queue.sv
// Trace request queue: circular FIFO behind a registered output slot with bypass.
// Optional issue counters are enabled by defining TRACE_QUEUE_STATS_EN.
module cache_trace_queue #(
   parameter int unsigned ADDRESS_SIZE = 16,
   parameter int unsigned DEPTH        = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   cache_trace_queue_if.slave           bus,
   input  logic                         flush,
   output logic [$clog2(DEPTH+2)-1:0]   occupancy
`ifdef TRACE_QUEUE_STATS_EN
   ,
   output logic [31:0]                  issued_reads,
   output logic [31:0]                  issued_writes
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned OCC_W = $clog2(DEPTH + 2);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ACTIVE,
      ST_FULL
   } status_t;

   logic [ADDRESS_SIZE:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      fifo_count;
   status_t               state;
   status_t               state_next;

   logic push;
   logic issue;
   logic slot_free;
   logic load_head;
   logic bypass;
   logic fifo_write;

   assign bus.in_ready = (fifo_count != FULL_COUNT) && !flush;
   assign push         = bus.in_valid && bus.in_ready;
   assign issue        = bus.req_valid && bus.cache_ready;
   assign slot_free    = !bus.req_valid || bus.cache_ready;
   assign load_head    = slot_free && (fifo_count != '0);
   assign bypass       = slot_free && (fifo_count == '0) && push;
   assign fifo_write   = push && !bypass;
   assign occupancy    = OCC_W'(fifo_count) + OCC_W'(bus.req_valid);

   always_ff @(posedge clk) begin
      if (fifo_write) begin
         mem[wr_ptr] <= {bus.in_rw, bus.in_address};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         bus.req_valid <= 1'b0;
         bus.rw        <= 1'b0;
         bus.address   <= '0;
      end else if (flush) begin
         // Presented rw/address are left as-is; only validity is dropped.
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         bus.req_valid <= 1'b0;
      end else begin
         if (fifo_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (load_head) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (fifo_write && !load_head) begin
            fifo_count <= fifo_count + 1'b1;
         end else if (load_head && !fifo_write) begin
            fifo_count <= fifo_count - 1'b1;
         end
         if (slot_free) begin
            if (load_head) begin
               {bus.rw, bus.address} <= mem[rd_ptr];
               bus.req_valid         <= 1'b1;
            end else if (bypass) begin
               {bus.rw, bus.address} <= {bus.in_rw, bus.in_address};
               bus.req_valid         <= 1'b1;
            end else begin
               bus.req_valid <= 1'b0;
            end
         end
      end
   end

`ifdef TRACE_QUEUE_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issued_reads  <= '0;
         issued_writes <= '0;
      end else if (issue && !flush) begin
         if (bus.rw) begin
            if (issued_writes != '1) issued_writes <= issued_writes + 32'd1;
         end else begin
            if (issued_reads != '1) issued_reads <= issued_reads + 32'd1;
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // FULL implies req_valid: a non-empty FIFO always refills a free output slot.
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY:  if (push) state_next = ST_ACTIVE;
            ST_ACTIVE: begin
               if (fifo_write && !load_head && (fifo_count == LAST_SLOT)) begin
                  state_next = ST_FULL;
               end else if (issue && !push && (occupancy == OCC_W'(1))) begin
                  state_next = ST_EMPTY;
               end
            end
            ST_FULL:   if (issue) state_next = ST_ACTIVE;
            default:   state_next = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert ((state == ST_EMPTY) == (occupancy == '0));
         assert ((state == ST_FULL) == (occupancy == OCC_W'(DEPTH + 1)));
      end
   end

endmodule

// File: tb/tb_cache_trace_queue.sv
// Self-checking bench for cache_trace_queue against an ordered-list reference
// model; counter checks are included when TRACE_QUEUE_STATS_EN is defined.
module tb_cache_trace_queue;

   localparam int unsigned AW    = 16;
   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   logic [$clog2(DEPTH+2)-1:0] occupancy;
`ifdef TRACE_QUEUE_STATS_EN
   logic [31:0] issued_reads;
   logic [31:0] issued_writes;
`endif

   cache_trace_queue_if #(.ADDRESS_SIZE(AW)) bus ();

   cache_trace_queue #(
      .ADDRESS_SIZE(AW),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave),
      .flush(flush),
      .occupancy(occupancy)
`ifdef TRACE_QUEUE_STATS_EN
      ,
      .issued_reads(issued_reads),
      .issued_writes(issued_writes)
`endif
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Model: element 0 is the presented access, the rest wait in push order.
   logic [AW:0]   q[$];
   logic          m_rw;
   logic [AW-1:0] m_addr;
   int unsigned   m_reads;
   int unsigned   m_writes;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_rw     = 1'b0;
      m_addr   = '0;
      m_reads  = 0;
      m_writes = 0;
   endtask

   task automatic compare_all();
      check("req_valid", 32'(bus.req_valid), 32'(q.size() > 0));
      check("occupancy", 32'(occupancy), 32'(q.size()));
      check("in_ready", 32'(bus.in_ready), 32'((q.size() <= DEPTH) && !flush));
      check("rw", 32'(bus.rw), 32'(m_rw));
      check("address", 32'(bus.address), 32'(m_addr));
`ifdef TRACE_QUEUE_STATS_EN
      check("issued_reads", issued_reads, m_reads);
      check("issued_writes", issued_writes, m_writes);
`endif
   endtask

   task automatic step(input logic v, input logic r, input logic [AW-1:0] a,
                       input logic cr, input logic fl);
      int unsigned sz;
      logic [AW:0] e;
      bus.in_valid    = v;
      bus.in_rw       = r;
      bus.in_address  = a;
      bus.cache_ready = cr;
      flush           = fl;
      @(posedge clk);
      sz = q.size();
      if (fl) begin
         q.delete();
      end else begin
         if (sz > 0 && cr) begin
            e = q.pop_front();
            if (e[AW]) m_writes++;
            else m_reads++;
         end
         if (v && sz <= DEPTH) q.push_back({r, a});
      end
      if (q.size() > 0) begin
         e      = q[0];
         m_rw   = e[AW];
         m_addr = e[AW-1:0];
      end
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.in_rw       = 1'b0;
      bus.in_address  = '0;
      bus.cache_ready = 1'b0;
      flush           = 1'b0;
      model_reset();
      do_reset();

      check("reset_req_valid", 32'(bus.req_valid), 32'd0);
      check("reset_rw", 32'(bus.rw), 32'd0);
      check("reset_address", 32'(bus.address), 32'd0);
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_occupancy", 32'(occupancy), 32'd0);

      // Single access through an empty queue
      step(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
      check("first_valid", 32'(bus.req_valid), 32'd1);
      check("first_address", 32'(bus.address), 32'h1234);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      check("first_drained", 32'(bus.req_valid), 32'd0);

      // Fill to DEPTH+1 with the consumer stalled, then offer one more
      for (int i = 0; i < 9; i++) step(1'b1, 1'($urandom_range(1)), 16'(i), 1'b0, 1'b0);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      check("full_occupancy", 32'(occupancy), 32'd9);
      step(1'b1, 1'b1, 16'h00AA, 1'b0, 1'b0);
      check("full_reject_occ", 32'(occupancy), 32'd9);
      for (int i = 0; i < 10; i++) begin
         check("drain_order", 32'(bus.address), 32'(i < 9 ? i : 8));
         step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      end

      // Alternating consumer with a push every cycle across pointer wrap
      for (int i = 0; i < 24; i++) step(1'b1, 1'($urandom_range(1)), 16'($urandom), 1'(~i[0]), 1'b0);
      for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Random traffic
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 16'($urandom),
              1'($urandom_range(2) == 0), 1'b0);

      // Flush with a concurrent offer from a 5-entry queue
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'(16'h0500 + i), 1'b0, 1'b0);
      check("pre_flush_occ", 32'(occupancy), 32'd5);
      step(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b1);
      check("flush_occ", 32'(occupancy), 32'd0);
      check("flush_valid", 32'(bus.req_valid), 32'd0);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      check("flush_discard", 32'(bus.req_valid), 32'd0);

      // Asynchronous reset between edges
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(16'h0300 + i), 1'b0, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      check("async_valid", 32'(bus.req_valid), 32'd0);
      check("async_occ", 32'(occupancy), 32'd0);
      check("async_address", 32'(bus.address), 32'd0);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

`ifdef TRACE_QUEUE_STATS_EN
      do_reset();
      step(1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
      step(1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
      step(1'b1, 1'b0, 16'h0003, 1'b1, 1'b0);
      step(1'b1, 1'b1, 16'h0004, 1'b1, 1'b0);
      step(1'b1, 1'b0, 16'h0005, 1'b1, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      check("stats_reads", issued_reads, 32'd3);
      check("stats_writes", issued_writes, 32'd2);
      step(1'b1, 1'b1, 16'h0006, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      check("stats_reads_flush", issued_reads, 32'd3);
      check("stats_writes_flush", issued_writes, 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
